logic_shift_unit: RTL and testbench
===================================

LOGIC_SHIFT_UNIT -- requirements
Module: logic_shift_unit

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits; legal values are powers of two, at least 2.
REQ-002 Port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_i  input  1  reset, synchronous and active-high.
REQ-004 Port: valid_i  input  1  request valid; operands and op presented this cycle.
REQ-005 Port: ready_o  output  1  unit can accept a request this cycle.
REQ-006 Port: op_i  input  3  operation select (see REQ-012).
REQ-007 Port: bus_a_i, bus_b_i  input  WIDTH  operands A and B.
REQ-008 Port: bus_s_o  output  WIDTH  registered result.
REQ-009 Port: zero_o, neg_o  output  1 each  registered flags: result==0, result MSB.
REQ-010 Port: valid_o  output  1  result valid; held until consumed.
REQ-011 Port: ready_i  input  1  downstream accepts result when valid_o and ready_i are both high.

Function
REQ-012 op_i encoding: 000 A&B; 001 A|B; 010 A^B; 011 ~A; 100 A logical-left-shift; 101 A logical-right-shift; 110 A arithmetic-right-shift; 111 pass B.
REQ-013 Shift amount k SHALL be bus_b_i[log2(WIDTH)-1:0] captured at acceptance; range 0..WIDTH-1; upper B bits ignored.
REQ-014 FSM states: IDLE, SHIFT, DONE; ready_o SHALL be 1 only in IDLE.
REQ-015 Acceptance: rising edge with state IDLE and valid_i=1; inputs SHALL be ignored in any other cycle.
REQ-016 IDLE, accept, op 000/001/010/011/111, or shift with k=0: bus_s_o <= result (A unchanged for k=0), flags updated, go DONE.
REQ-017 IDLE, accept, shift op with k>0: load A into working register and k into down-counter, go SHIFT.
REQ-018 SHIFT: each edge shifts working register one bit (zero-fill for SLL/SRL, MSB replicate for SRA) and decrements counter; on the edge where counter==1, the shifted value SHALL be written to bus_s_o with flags and the state SHALL go to DONE.
REQ-019 Latency, acceptance edge to first cycle of valid_o=1: 1 cycle for logic ops and k=0; k+1 cycles for shifts with k>0.
REQ-020 DONE: valid_o=1; bus_s_o, zero_o, neg_o stable; on edge with ready_i=1 go IDLE; otherwise remain in DONE indefinitely.
REQ-021 No same-cycle turnaround: a new request SHALL NOT be accepted in the cycle a result is consumed (ready_o=0 in DONE).
REQ-022 bus_s_o and flags SHALL hold their last value in IDLE and SHIFT until overwritten by the next result.
REQ-023 valid_o SHALL be 0 in IDLE and SHIFT; ready_i SHALL be ignored outside DONE.
REQ-024 zero_o and neg_o SHALL always be consistent with the bus_s_o value they are registered alongside.

Reset
REQ-025 rst_i=1 at a rising edge SHALL force state IDLE, bus_s_o=0, zero_o=1, neg_o=0, valid_o=0, counter=0, working register=0, overriding any other activity.
REQ-026 Reset mid-SHIFT or in DONE SHALL abandon the operation; no valid_o pulse for it after reset deasserts.
REQ-027 ready_o SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-028 WIDTH=4, op=000, A=1100, B=1010, ready_i=1 -> next cycle valid_o=1, bus_s_o=1000, zero_o=0, neg_o=1; IDLE one cycle later.
REQ-029 op=100, A=0011, B=0010 (k=2) -> valid_o low 2 cycles, then bus_s_o=1100, neg_o=1; op=110, A=1000, k=3 -> bus_s_o=1111 after 4 cycles.
REQ-030 op=101, A=0001, k=1 -> bus_s_o=0000, zero_o=1; op=100, k=0, A=0101 -> bus_s_o=0101 with 1-cycle latency.
REQ-031 Backpressure: result in DONE, ready_i=0 for 5 cycles while valid_i=1 with new operands -> valid_o and bus_s_o stable, ready_o=0, new request not taken until after consumption.
REQ-032 Reset asserted in second SHIFT cycle of k=3 shift -> next cycle all outputs at reset values, ready_o=1, no stale valid_o.
REQ-033 Random op/operand stream with random ready_i against a reference model: every result, flag and latency per REQ-019 matches; no request dropped or duplicated.

Source files
------------

// File: rtl/logic_shift_unit.sv
// Logic/shift unit: bitwise ops and pass-B in one cycle; shifts walk a working register one bit per cycle.
// Latency: 1 cycle for logic ops and zero-distance shifts, k+1 cycles for a shift by k>0.
// Backpressure: single-entry; result held in DONE until ready_i, ready_o only while IDLE.
module logic_shift_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] bus_a_i,
    input  logic [WIDTH-1:0] bus_b_i,
    output logic [WIDTH-1:0] bus_s_o,
    output logic             zero_o,
    output logic             neg_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOTA = 3'b011;
    localparam logic [2:0] OP_SLL  = 3'b100;
    localparam logic [2:0] OP_SRL  = 3'b101;
    localparam logic [2:0] OP_SRA  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] work_q;
    logic [SW-1:0]    cnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] bus_s_q;
    logic             zero_q;
    logic             neg_q;
    logic             valid_q;
    logic             ready_q;

    logic [SW-1:0]    amt;
    logic             is_shift;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] shift_d;
    logic             unused_b_hi;

    // Only the low log2(WIDTH) bits of B form the shift distance.
    assign amt         = bus_b_i[SW-1:0];
    assign unused_b_hi = ^bus_b_i[WIDTH-1:SW];
    assign is_shift    = (op_i == OP_SLL) || (op_i == OP_SRL) || (op_i == OP_SRA);

    // Single-cycle result: bitwise ops, pass-B, and shifts by zero (A unchanged).
    always_comb begin
        res_d = '0;
        case (op_i)
            OP_AND:  res_d = bus_a_i & bus_b_i;
            OP_OR:   res_d = bus_a_i | bus_b_i;
            OP_XOR:  res_d = bus_a_i ^ bus_b_i;
            OP_NOTA: res_d = ~bus_a_i;
            OP_PASS: res_d = bus_b_i;
            default: res_d = bus_a_i;
        endcase
    end

    // One-bit step of the working register for the captured shift kind.
    always_comb begin
        shift_d = work_q;
        case (op_q)
            OP_SLL:  shift_d = {work_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_d = {1'b0, work_q[WIDTH-1:1]};
            OP_SRA:  shift_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: shift_d = work_q;
        endcase
    end

    // Control FSM with registered result, flags and handshake outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= OP_AND;
            bus_s_q <= '0;
            zero_q  <= 1'b1;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        op_q    <= op_i;
                        ready_q <= 1'b0;
                        if (is_shift && (amt != '0)) begin
                            work_q  <= bus_a_i;
                            cnt_q   <= amt;
                            state_q <= SHIFT;
                        end else begin
                            bus_s_q <= res_d;
                            zero_q  <= (res_d == '0);
                            neg_q   <= res_d[WIDTH-1];
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    work_q <= shift_d;
                    cnt_q  <= cnt_q - SW'(1);
                    // Last step: publish the shifted value together with its flags.
                    if (cnt_q == SW'(1)) begin
                        bus_s_q <= shift_d;
                        zero_q  <= (shift_d == '0);
                        neg_q   <= shift_d[WIDTH-1];
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // ready_o stays low on the consume edge, so no same-cycle turnaround.
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign bus_s_o = bus_s_q;
    assign zero_o  = zero_q;
    assign neg_o   = neg_q;

endmodule

// File: tb/tb_logic_shift_unit.sv
// Bench for logic_shift_unit: directed checks of the documented examples plus a randomized stream
// against a plain-arithmetic reference model with random backpressure and ignored-input noise.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_logic_shift_unit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic         ready_o;
    logic [2:0]   op_i;
    logic [W-1:0] bus_a_i;
    logic [W-1:0] bus_b_i;
    logic [W-1:0] bus_s_o;
    logic         zero_o;
    logic         neg_o;
    logic         valid_o;
    logic         ready_i;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    logic_shift_unit #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .op_i    (op_i),
        .bus_a_i (bus_a_i),
        .bus_b_i (bus_b_i),
        .bus_s_o (bus_s_o),
        .zero_o  (zero_o),
        .neg_o   (neg_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    // Reference result from the operation table.
    function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        int k;
        logic signed [W-1:0] sa;
        logic [W-1:0] r;
        k  = int'(b) % W;
        sa = a;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~a;
            3'd4:    r = a << k;
            3'd5:    r = a >> k;
            3'd6:    r = sa >>> k;
            default: r = b;
        endcase
        return r;
    endfunction

    // Reference latency: shifts by k>0 take k+1 cycles, everything else 1.
    function automatic int ref_latency(input logic [2:0] op, input logic [W-1:0] b);
        int k;
        k = int'(b) % W;
        if (op >= 3'd4 && op <= 3'd6 && k != 0) return k + 1;
        return 1;
    endfunction

    // Present one request, then count falling edges until valid_o (lat=-1 on timeout).
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit noise, output int lat);
        int guard;
        guard   = 0;
        lat     = -1;
        valid_i = 1'b0;
        while (ready_o !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) return;
        valid_i = 1'b1;
        op_i    = op;
        bus_a_i = a;
        bus_b_i = b;
        @(negedge clk);
        valid_i = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (valid_o === 1'b1) begin
                lat = n;
                break;
            end
            if (noise) begin
                valid_i = 1'($urandom_range(0, 1));
                op_i    = 3'($urandom);
                bus_a_i = W'($urandom);
                bus_b_i = W'($urandom);
            end
            @(negedge clk);
        end
        valid_i = 1'b0;
    endtask

    task automatic consume();
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        op_i    = '0;
        bus_a_i = '0;
        bus_b_i = '0;
        repeat (3) @(negedge clk);
        tests++;
        if (bus_s_o !== 4'b0000 || zero_o !== 1'b1 || neg_o !== 1'b0 || valid_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got s=%b z=%b n=%b v=%b, want s=0000 z=1 n=0 v=0",
                     bus_s_o, zero_o, neg_o, valid_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
        tests++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got ready_o=%b valid_o=%b, want 1 0", ready_o, valid_o);
        end
    endtask

    task automatic test_logic();
        logic [2:0]   ops [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
        logic [W-1:0] as  [5] = '{4'b1100, 4'b1100, 4'b1111, 4'b1111, 4'b1010};
        logic [W-1:0] bs  [5] = '{4'b1010, 4'b0011, 4'b1111, 4'b0110, 4'b0000};
        logic [W-1:0] ex  [5] = '{4'b1000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
        int lat;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i], 1'b0, lat);
            tests++;
            if (lat !== 1 || bus_s_o !== ex[i] || zero_o !== (ex[i] == 4'b0000) ||
                neg_o !== ex[i][W-1]) begin
                fails++;
                $display("FAIL logic_op%0d: got lat=%0d s=%b z=%b n=%b, want lat=1 s=%b z=%b n=%b",
                         ops[i], lat, bus_s_o, zero_o, neg_o, ex[i], (ex[i] == 4'b0000), ex[i][W-1]);
            end
            consume();
            tests++;
            if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
                fails++;
                $display("FAIL logic_idle_after: got ready_o=%b valid_o=%b, want 1 0", ready_o, valid_o);
            end
        end
    endtask

    task automatic test_shift();
        logic [2:0]   ops [5] = '{3'd4, 3'd6, 3'd5, 3'd4, 3'd5};
        logic [W-1:0] as  [5] = '{4'b0011, 4'b1000, 4'b0001, 4'b0101, 4'b1000};
        logic [W-1:0] bs  [5] = '{4'b0010, 4'b0011, 4'b0001, 4'b0000, 4'b1110};
        logic [W-1:0] ex  [5] = '{4'b1100, 4'b1111, 4'b0000, 4'b0101, 4'b0010};
        int           el  [5] = '{3, 4, 2, 1, 3};
        int lat;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i], 1'b0, lat);
            tests++;
            if (lat !== el[i] || bus_s_o !== ex[i] || zero_o !== (ex[i] == 4'b0000) ||
                neg_o !== ex[i][W-1]) begin
                fails++;
                $display("FAIL shift_%0d: got lat=%0d s=%b z=%b n=%b, want lat=%0d s=%b z=%b n=%b",
                         i, lat, bus_s_o, zero_o, neg_o, el[i], ex[i], (ex[i] == 4'b0000), ex[i][W-1]);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        issue(3'd0, 4'b1100, 4'b1010, 1'b0, lat);
        ready_i = 1'b0;
        valid_i = 1'b1;
        op_i    = 3'd1;
        bus_a_i = 4'b0101;
        bus_b_i = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || bus_s_o !== 4'b1000 || neg_o !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold%0d: got v=%b r=%b s=%b n=%b, want v=1 r=0 s=1000 n=1",
                         c, valid_o, ready_o, bus_s_o, neg_o);
            end
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        tests++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || bus_s_o !== 4'b1000) begin
            fails++;
            $display("FAIL bp_no_turnaround: got v=%b r=%b s=%b, want v=0 r=1 s=1000",
                     valid_o, ready_o, bus_s_o);
        end
        @(negedge clk);
        valid_i = 1'b0;
        tests++;
        if (valid_o !== 1'b1 || bus_s_o !== 4'b0111 || zero_o !== 1'b0 || neg_o !== 1'b0) begin
            fails++;
            $display("FAIL bp_next_req: got v=%b s=%b z=%b n=%b, want v=1 s=0111 z=0 n=0",
                     valid_o, bus_s_o, zero_o, neg_o);
        end
        consume();
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        valid_i = 1'b1;
        op_i    = 3'd6;
        bus_a_i = 4'b1000;
        bus_b_i = 4'b0011;
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        tests++;
        if (bus_s_o !== 4'b0000 || zero_o !== 1'b1 || neg_o !== 1'b0 || valid_o !== 1'b0 ||
            ready_o !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_shift: got s=%b z=%b n=%b v=%b r=%b, want s=0000 z=1 n=0 v=0 r=1",
                     bus_s_o, zero_o, neg_o, valid_o, ready_o);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests++;
            if (valid_o !== 1'b0) begin
                fails++;
                $display("FAIL rst_stale_valid%0d: got valid_o=%b, want 0", c, valid_o);
            end
        end
        issue(3'd4, 4'b0001, 4'b0011, 1'b0, lat);
        tests++;
        if (lat !== 4 || bus_s_o !== 4'b1000 || neg_o !== 1'b1) begin
            fails++;
            $display("FAIL rst_recover: got lat=%0d s=%b n=%b, want lat=4 s=1000 n=1", lat, bus_s_o, neg_o);
        end
        consume();
    endtask

    task automatic test_random();
        logic [2:0]   op;
        logic [W-1:0] a, b, exp_s;
        int lat, exp_lat;
        bit taken;
        for (int t = 0; t < 80; t++) begin
            op      = 3'($urandom_range(0, 7));
            a       = W'($urandom);
            b       = W'($urandom);
            exp_s   = ref_result(op, a, b);
            exp_lat = ref_latency(op, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(op, a, b, 1'b1, lat);
            tests++;
            if (lat !== exp_lat || bus_s_o !== exp_s || zero_o !== (exp_s == '0) ||
                neg_o !== exp_s[W-1]) begin
                fails++;
                $display("FAIL rand%0d op=%0d a=%b b=%b: got lat=%0d s=%b z=%b n=%b, want lat=%0d s=%b z=%b n=%b",
                         t, op, a, b, lat, bus_s_o, zero_o, neg_o, exp_lat, exp_s, (exp_s == '0), exp_s[W-1]);
            end
            taken = 1'b0;
            for (int c = 0; c < 20 && !taken; c++) begin
                ready_i = (c == 19) ? 1'b1 : 1'($urandom_range(0, 1));
                valid_i = 1'($urandom_range(0, 1));
                op_i    = 3'($urandom);
                bus_a_i = W'($urandom);
                bus_b_i = W'($urandom);
                taken   = ready_i;
                @(negedge clk);
                if (!taken) begin
                    tests++;
                    if (valid_o !== 1'b1 || bus_s_o !== exp_s || ready_o !== 1'b0) begin
                        fails++;
                        $display("FAIL rand%0d_hold: got v=%b s=%b r=%b, want v=1 s=%b r=0",
                                 t, valid_o, bus_s_o, ready_o, exp_s);
                    end
                end
            end
            ready_i = 1'b0;
            valid_i = 1'b0;
            tests++;
            if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
                fails++;
                $display("FAIL rand%0d_consumed: got v=%b r=%b, want v=0 r=1", t, valid_o, ready_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_logic();
        test_shift();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
